cyber_player: RTL and testbench

- Automated opponent for the tug-of-war playfield. Drives the same one-cycle "press" signal a conditioned human key (L or R) delivers to the light chain, so it is the transmitting end of the player-input interface the lights and victory logic consume.
- Press rate is set by a difficulty word from the board switches.
- Uses a prescaler tick, an LFSR random source and a press/hold-off state machine.
- Halts while the victory logic reports a winner.

---
 rtl/tug_pkg.sv | 25 ++
 rtl/cyber_player_tick_gen.sv | 35 +++
 rtl/cyber_player.sv | 150 +++++++++++++++
 tb/tb_cyber_player.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// -----------------------------------------------------------------------------
// tug_pkg
// Shared definitions for the tug-of-war playfield blocks.
//   cp_state_t         : cyber_player press/hold-off state machine encoding
//   LFSR_W_DEF         : default LFSR width (also the difficulty width)
//   LFSR_TAP_A/B       : feedback taps for x^10 + x^7 + 1 (Fibonacci, shift left)
//   DEFAULT_SEED       : LFSR reset value, nonzero
//   PRESS_CNT_W        : width of the saturating press counter
// -----------------------------------------------------------------------------
package tug_pkg;

  localparam int LFSR_W_DEF = 10;
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;
  localparam logic [LFSR_W_DEF-1:0] DEFAULT_SEED = 10'h2A5;
  localparam int PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PRESS = 2'd2,
    ST_HOLD  = 2'd3
  } cp_state_t;

endpackage

// File: rtl/cyber_player_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler. Counts 0..TICK_DIV-1 and wraps; tick is high for the
// single cycle in which the count sits at TICK_DIV-1.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-low reset (clears the count)
//   tick  out one-cycle decision tick
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/cyber_player.sv
// -----------------------------------------------------------------------------
// cyber_player
// Automated tug-of-war opponent. On each decision tick an LFSR sample is
// compared with the difficulty word; a hit produces a one-cycle press pulse,
// followed by a forced release of HOLD_TICKS ticks.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-low reset
//   enable      in  1 = player active; 0 = output suppressed, LFSR frozen
//   difficulty  in  press threshold, 0 = never press
//   game_over   in  1 while a winner is displayed; halts the player
//   press       out one-cycle press pulse (registered)
//   press_count out presses issued since reset, saturating at 255
// -----------------------------------------------------------------------------
module cyber_player
  import tug_pkg::*;
#(
  parameter int                LFSR_W     = LFSR_W_DEF,
  parameter int                TICK_DIV   = 1000000,
  parameter int                HOLD_TICKS = 2,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(DEFAULT_SEED)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LFSR_W-1:0]      difficulty,
  input  logic                   game_over,
  output logic                   press,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    // An all-zero register would lock up the feedback; reload the seed instead.
    if (v == '0) begin
      return SEED;
    end
    return {v[LFSR_W-2:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
  endfunction

  function automatic logic [PRESS_CNT_W-1:0] sat_inc(input logic [PRESS_CNT_W-1:0] v);
    if (v == '1) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  logic              tick;
  logic              active;
  logic              hit;
  logic [LFSR_W-1:0] lfsr;
  logic [HOLD_W-1:0] hold_cnt;
  cp_state_t         state;
  cp_state_t         state_next;
  logic              hold_load;
  logic              hold_dec;
  logic              hold_clr;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign active = enable && !game_over;
  // Decision uses the LFSR value held during the tick cycle, before it steps.
  assign hit    = (lfsr < difficulty);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= SEED;
    end else if (tick && enable) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    hold_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (active) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!active) begin
          state_next = ST_IDLE;
        end else if (tick && hit) begin
          state_next = ST_PRESS;
        end
      end
      ST_PRESS: begin
        // The press cycle always completes; an override only changes where it lands.
        if (active) begin
          state_next = ST_HOLD;
          hold_load  = 1'b1;
        end else begin
          state_next = ST_IDLE;
          hold_clr   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!active) begin
          state_next = ST_IDLE;
          hold_clr   = 1'b1;
        end else if (tick) begin
          hold_dec = 1'b1;
          if (hold_cnt <= HOLD_W'(1)) begin
            state_next = ST_ARMED;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        hold_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      press       <= 1'b0;
      press_count <= '0;
      hold_cnt    <= '0;
    end else begin
      state <= state_next;
      // Dedicated flop so the pulse carries no decode glitches.
      press <= (state_next == ST_PRESS);
      if (state == ST_PRESS) begin
        press_count <= sat_inc(press_count);
      end
      if (hold_clr) begin
        hold_cnt <= '0;
      end else if (hold_load) begin
        hold_cnt <= HOLD_LOAD;
      end else if (hold_dec && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cyber_player.sv
module tb_cyber_player;
  import tug_pkg::*;

  localparam int TD = 4;
  localparam int HT = 2;
  localparam logic [9:0] SD = 10'h2A5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] difficulty = 10'd0;
  logic       press;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  cyber_player #(
    .LFSR_W     (10),
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT),
    .SEED       (SD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .difficulty  (difficulty),
    .game_over   (game_over),
    .press       (press),
    .press_count (press_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;
  exp_t q[$];

  // Reference model state: cycle numbering, prescaler phase, tick index,
  // hold-off window, LFSR sequence and press tally.
  int         cyc = 0;
  int         mpre = 0;
  int         tk = 0;
  int         next_ok = 0;
  bit         cleared = 1'b1;
  bit         prev_act = 1'b0;
  logic [9:0] mlfsr = SD;
  int         mcount = 0;
  bit         last_rst_low = 1'b1;
  int         zap_req = 0;
  int         zap_seen = 0;
  bit         chk_tick = 1'b0;

  function automatic logic [9:0] ref_step(input logic [9:0] v);
    int x;
    int fb;
    x = int'(v);
    if (x == 0) return SD;
    fb = ((x / 512) + (x / 64)) % 2;
    return 10'((x * 2) % 1024 + fb);
  endfunction

  always @(posedge clk) begin
    bit   act;
    bit   mtick;
    exp_t e;
    cyc++;
    if (!reset) begin
      mpre = 0;
      mlfsr = SD;
      cleared = 1'b1;
      prev_act = 1'b0;
      mcount = 0;
      last_rst_low = 1'b1;
    end else begin
      last_rst_low = 1'b0;
      if (zap_req != zap_seen) begin
        mlfsr = 10'd0;
        zap_seen = zap_req;
      end
      act = enable && !game_over;
      mtick = (mpre == TD - 1);
      if (mtick && act && prev_act && (mlfsr < difficulty) && (cleared || tk >= next_ok)) begin
        if (mcount < 255) mcount++;
        e.cyc = cyc;
        e.cnt = mcount;
        q.push_back(e);
        next_ok = tk + HT + 1;
        cleared = 1'b0;
      end
      if (!act) cleared = 1'b1;
      if (mtick && enable) mlfsr = ref_step(mlfsr);
      if (mtick) tk++;
      mpre = (mpre + 1) % TD;
      prev_act = act;
    end
  end

  // Monitor / scoreboard
  bit pend = 1'b0;
  int pend_val = 0;

  always @(negedge clk) begin
    int expv;
    if (pend) begin
      expv = last_rst_low ? 0 : pend_val;
      checks++;
      if (int'(press_count) != expv) begin
        errors++;
        $display("FAIL press_count after press: got %0d want %0d (cyc %0d)", press_count, expv, cyc);
      end
      checks++;
      if (press !== 1'b0) begin
        errors++;
        $display("FAIL press_width: press still %b one cycle later (cyc %0d)", press, cyc);
      end
      pend = 1'b0;
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_press: press absent, want press at cyc %0d (now %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (press === 1'b1) begin
      checks++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        pend = 1'b1;
        pend_val = q[0].cnt;
        void'(q.pop_front());
      end else begin
        errors++;
        $display("FAIL unexpected_press: press=1 at cyc %0d, want 0", cyc);
      end
    end
    checks++;
    if (dut.lfsr !== mlfsr) begin
      errors++;
      $display("FAIL lfsr: got %h want %h (cyc %0d)", dut.lfsr, mlfsr, cyc);
    end
    if (chk_tick) begin
      checks++;
      if (dut.u_tick.tick !== (mpre == TD - 1)) begin
        errors++;
        $display("FAIL tick: got %b want %b (cyc %0d)", dut.u_tick.tick, (mpre == TD - 1), cyc);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (press === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_press_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run(2);
    reset = 1'b1;
  endtask

  initial begin
    bit ok;
    int t_rel;
    int t_hit;

    // 1: difficulty 0 never presses; tick on every 4th cycle
    enable = 1'b1;
    game_over = 1'b0;
    difficulty = 10'd0;
    do_reset();
    chk("reset_press", int'(press), 0);
    chk("reset_count", int'(press_count), 0);
    chk("reset_state", int'(dut.state), int'(ST_IDLE));
    chk_tick = 1'b1;
    run(400);
    chk_tick = 1'b0;
    chk("diff0_count", int'(press_count), 0);

    // 2/3: maximum difficulty from reset, runs into saturation
    difficulty = 10'h3FF;
    do_reset();
    run(4000);
    chk("sat_count", int'(press_count), 255);
    run(30);
    chk("sat_hold", int'(press_count), 255);

    // 4: game_over raised during the press cycle
    wait_press(50, ok);
    game_over = 1'b1;
    run(40);
    game_over = 1'b0;
    t_rel = cyc;
    wait_press(50, ok);
    chk("resume_gap_ge_tick", int'(cyc - t_rel >= TD), 1);

    // 5: reset pulse inside the hold-off window
    wait_press(50, ok);
    run(2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("hold_reset_press", int'(press), 0);
    chk("hold_reset_count", int'(press_count), 0);
    chk("hold_reset_state", int'(dut.state), int'(ST_IDLE));
    chk("hold_reset_lfsr", int'(dut.lfsr), int'(SD));
    run(40);

    // 6: LFSR forced to zero reloads the seed on its next step
    while (mpre != 0) @(negedge clk);
    #2;
    force dut.lfsr = 10'd0;
    zap_req++;
    #1;
    release dut.lfsr;
    @(negedge clk);
    while (mpre != 0) @(negedge clk);
    chk("lockup_reload", int'(dut.lfsr), int'(SD));
    run(60);

    // 7: randomized difficulty / enable / game_over traffic
    for (int s = 0; s < 40; s++) begin
      difficulty = 10'($urandom_range(0, 1023));
      if (s % 7 == 3) difficulty = 10'h3FF;
      enable = ($urandom_range(0, 9) != 0);
      game_over = ($urandom_range(0, 7) == 0);
      run($urandom_range(60, 120));
    end
    enable = 1'b1;
    game_over = 1'b0;
    difficulty = 10'h3FF;
    t_hit = cyc;
    wait_press(100, ok);
    chk("final_press_seen", int'(ok), 1);
    run(10);
    chk("queue_drained", q.size(), 0);
    chk("final_count", int'(press_count), mcount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
